// File: rtl/frame_buf_arbiter.sv
`default_nettype none
// =====================================================================
// frame_buf_arbiter: round-robin SDRAM burst scheduler for the camera
// write FIFO and the display read FIFO, with frame-relative addressing.
// Revision: 1.0
// =====================================================================
module frame_buf_arbiter #(
    parameter int ADDR_W      = 24,
    parameter int LVL_W       = 11,
    parameter int BURST_LEN   = 256,
    parameter int FRAME_WORDS = 307200,
    parameter int WR_BASE     = 0,
    parameter int RD_BASE     = 0,
    parameter int RD_LOW      = 256
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              init_done,
    input  logic [LVL_W-1:0]  wr_fifo_level,
    input  logic [LVL_W-1:0]  rd_fifo_level,
    input  logic              rd_enable,
    input  logic              wr_frame_start,
    input  logic              rd_frame_start,
    input  logic              sdram_ack,
    input  logic              sdram_done,
    output logic              sdram_wr_req,
    output logic              sdram_rd_req,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic              busy,
    output logic              wr_frame_done
);

    localparam logic [2:0] c_st_idle     = 3'd0;
    localparam logic [2:0] c_st_wr_req   = 3'd1;
    localparam logic [2:0] c_st_wr_burst = 3'd2;
    localparam logic [2:0] c_st_rd_req   = 3'd3;
    localparam logic [2:0] c_st_rd_burst = 3'd4;

    localparam logic c_grant_wr = 1'b0;
    localparam logic c_grant_rd = 1'b1;

    localparam logic [LVL_W-1:0]  c_burst_lvl   = LVL_W'(BURST_LEN);
    localparam logic [LVL_W-1:0]  c_rd_low      = LVL_W'(RD_LOW);
    localparam logic [ADDR_W-1:0] c_burst_words = ADDR_W'(BURST_LEN);
    localparam logic [ADDR_W-1:0] c_wr_base     = ADDR_W'(WR_BASE);
    localparam logic [ADDR_W-1:0] c_rd_base     = ADDR_W'(RD_BASE);
    localparam logic [ADDR_W-1:0] c_wr_end      = ADDR_W'(WR_BASE + FRAME_WORDS);
    localparam logic [ADDR_W-1:0] c_rd_end      = ADDR_W'(RD_BASE + FRAME_WORDS);

    logic [2:0]        state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              wr_resync_q, wr_resync_d;
    logic              rd_resync_q, rd_resync_d;
    logic              sdram_wr_req_q, sdram_wr_req_d;
    logic              sdram_rd_req_q, sdram_rd_req_d;
    logic [ADDR_W-1:0] sdram_addr_q, sdram_addr_d;
    logic              busy_q, busy_d;
    logic              wr_frame_done_q, wr_frame_done_d;

    logic              w_wr_elig;
    logic              w_rd_elig;
    logic              w_wr_active;
    logic              w_rd_active;
    logic              w_wr_complete;
    logic              w_rd_complete;
    logic [ADDR_W-1:0] w_wr_addr_inc;
    logic [ADDR_W-1:0] w_rd_addr_inc;

    assign w_wr_elig     = init_done && (wr_fifo_level >= c_burst_lvl);
    assign w_rd_elig     = init_done && rd_enable && (rd_fifo_level <= c_rd_low);
    assign w_wr_active   = (state_q == c_st_wr_req) || (state_q == c_st_wr_burst);
    assign w_rd_active   = (state_q == c_st_rd_req) || (state_q == c_st_rd_burst);
    assign w_wr_complete = (state_q == c_st_wr_burst) && sdram_done;
    assign w_rd_complete = (state_q == c_st_rd_burst) && sdram_done;
    assign w_wr_addr_inc = wr_addr_q + c_burst_words;
    assign w_rd_addr_inc = rd_addr_q + c_burst_words;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= c_st_idle;
            last_grant_q <= c_grant_rd;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    // On a tie the path that did not win last time is granted.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            c_st_idle: begin
                if (w_wr_elig && (!w_rd_elig || (last_grant_q == c_grant_rd))) begin
                    state_d      = c_st_wr_req;
                    last_grant_d = c_grant_wr;
                end else if (w_rd_elig) begin
                    state_d      = c_st_rd_req;
                    last_grant_d = c_grant_rd;
                end
            end
            c_st_wr_req: begin
                if (sdram_ack) begin
                    state_d = c_st_wr_burst;
                end
            end
            c_st_wr_burst: begin
                if (sdram_done) begin
                    state_d = c_st_idle;
                end
            end
            c_st_rd_req: begin
                if (sdram_ack) begin
                    state_d = c_st_rd_burst;
                end
            end
            c_st_rd_burst: begin
                if (sdram_done) begin
                    state_d = c_st_idle;
                end
            end
            default: begin
                state_d = c_st_idle;
            end
        endcase
    end

    // A frame start seen mid-transaction is deferred to burst completion.
    always_comb begin
        wr_addr_d       = wr_addr_q;
        wr_resync_d     = wr_resync_q;
        wr_frame_done_d = 1'b0;
        if (w_wr_complete) begin
            wr_resync_d = 1'b0;
            if (wr_resync_q || wr_frame_start) begin
                wr_addr_d = c_wr_base;
            end else if (w_wr_addr_inc == c_wr_end) begin
                wr_addr_d       = c_wr_base;
                wr_frame_done_d = 1'b1;
            end else begin
                wr_addr_d = w_wr_addr_inc;
            end
        end else if (wr_frame_start) begin
            if (w_wr_active) begin
                wr_resync_d = 1'b1;
            end else begin
                wr_addr_d = c_wr_base;
            end
        end

        rd_addr_d   = rd_addr_q;
        rd_resync_d = rd_resync_q;
        if (w_rd_complete) begin
            rd_resync_d = 1'b0;
            if (rd_resync_q || rd_frame_start || (w_rd_addr_inc == c_rd_end)) begin
                rd_addr_d = c_rd_base;
            end else begin
                rd_addr_d = w_rd_addr_inc;
            end
        end else if (rd_frame_start) begin
            if (w_rd_active) begin
                rd_resync_d = 1'b1;
            end else begin
                rd_addr_d = c_rd_base;
            end
        end
    end

    // Outputs are decoded from the next state so they are registered yet
    // line up with the state they describe.
    always_comb begin
        sdram_wr_req_d = (state_d == c_st_wr_req);
        sdram_rd_req_d = (state_d == c_st_rd_req);
        busy_d         = (state_d != c_st_idle);
        sdram_addr_d   = '0;
        if (state_d == c_st_wr_req) begin
            sdram_addr_d = wr_addr_d;
        end else if (state_d == c_st_rd_req) begin
            sdram_addr_d = rd_addr_d;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_addr_q       <= c_wr_base;
            rd_addr_q       <= c_rd_base;
            wr_resync_q     <= 1'b0;
            rd_resync_q     <= 1'b0;
            sdram_wr_req_q  <= 1'b0;
            sdram_rd_req_q  <= 1'b0;
            sdram_addr_q    <= '0;
            busy_q          <= 1'b0;
            wr_frame_done_q <= 1'b0;
        end else begin
            wr_addr_q       <= wr_addr_d;
            rd_addr_q       <= rd_addr_d;
            wr_resync_q     <= wr_resync_d;
            rd_resync_q     <= rd_resync_d;
            sdram_wr_req_q  <= sdram_wr_req_d;
            sdram_rd_req_q  <= sdram_rd_req_d;
            sdram_addr_q    <= sdram_addr_d;
            busy_q          <= busy_d;
            wr_frame_done_q <= wr_frame_done_d;
        end
    end

    assign sdram_wr_req  = sdram_wr_req_q;
    assign sdram_rd_req  = sdram_rd_req_q;
    assign sdram_addr    = sdram_addr_q;
    assign busy          = busy_q;
    assign wr_frame_done = wr_frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_buf_arbiter.sv
`default_nettype none
// =====================================================================
// tb_frame_buf_arbiter: scoreboard bench driving a simple SDRAM
// controller model against frame_buf_arbiter.
// Revision: 1.0
// =====================================================================
module tb_frame_buf_arbiter;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        init_done;
    logic [10:0] wr_fifo_level;
    logic [10:0] rd_fifo_level;
    logic        rd_enable;
    logic        wr_frame_start;
    logic        rd_frame_start;
    logic        sdram_ack;
    logic        sdram_done;
    logic        sdram_wr_req;
    logic        sdram_rd_req;
    logic [23:0] sdram_addr;
    logic        busy;
    logic        wr_frame_done;

    typedef struct packed {
        logic        wr;
        logic [23:0] addr;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   n_bursts = 0;
    int   n_wfd = 0;
    int   rise_cyc = 0;
    int   done_cyc = 0;
    int   wfd_cyc = 0;
    int   req_len_cur = 0;
    int   last_req_len = 0;
    bit   req_prev = 1'b0;
    bit   req_now;
    bit   hung = 1'b0;
    exp_t mon_e;

    frame_buf_arbiter #(
        .ADDR_W(24), .LVL_W(11), .BURST_LEN(256), .FRAME_WORDS(307200),
        .WR_BASE(0), .RD_BASE(0), .RD_LOW(256)
    ) dut (
        .sys_clk        (sys_clk),
        .sys_rst_n      (sys_rst_n),
        .init_done      (init_done),
        .wr_fifo_level  (wr_fifo_level),
        .rd_fifo_level  (rd_fifo_level),
        .rd_enable      (rd_enable),
        .wr_frame_start (wr_frame_start),
        .rd_frame_start (rd_frame_start),
        .sdram_ack      (sdram_ack),
        .sdram_done     (sdram_done),
        .sdram_wr_req   (sdram_wr_req),
        .sdram_rd_req   (sdram_rd_req),
        .sdram_addr     (sdram_addr),
        .busy           (busy),
        .wr_frame_done  (wr_frame_done)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard: every request rising edge pops the next expected burst.
    always @(negedge sys_clk) begin
        req_now = sdram_wr_req | sdram_rd_req;
        if (req_now && !req_prev) begin
            n_bursts++;
            rise_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("burst_unexpected", exp_q.size(), 1);
            end else begin
                mon_e = exp_q.pop_front();
                check("burst_kind", {31'd0, sdram_wr_req}, {31'd0, mon_e.wr});
                check("burst_addr", {8'd0, sdram_addr}, {8'd0, mon_e.addr});
            end
        end
        if (req_now) begin
            req_len_cur++;
        end else if (req_prev) begin
            last_req_len = req_len_cur;
            req_len_cur  = 0;
        end
        if (wr_frame_done) begin
            n_wfd++;
            wfd_cyc = cyc;
        end
        req_prev = req_now;
    end

    task automatic push(input bit wr, input int addr);
        exp_t e;
        e.wr   = wr;
        e.addr = 24'(addr);
        exp_q.push_back(e);
    endtask

    task automatic wait_req(output bit ok);
        int n;
        n = 0;
        while (!(sdram_wr_req || sdram_rd_req) && n < 2000) begin
            @(negedge sys_clk);
            n++;
        end
        ok = (n < 2000);
        check("req_wait", {31'd0, ok}, 32'd1);
        if (!ok) hung = 1'b1;
    endtask

    task automatic ack_req(input int ack_dly, input bit drop_rd);
        if (drop_rd) rd_enable = 1'b0;
        repeat (ack_dly - 1) @(negedge sys_clk);
        sdram_ack = 1'b1;
        @(negedge sys_clk);
        sdram_ack = 1'b0;
        check("req_drop", {31'd0, sdram_wr_req | sdram_rd_req}, 32'd0);
    endtask

    // fs_mode: 0 none, 1 vsync mid-burst, 2 vsync coincident with done
    task automatic finish_burst(input int done_dly, input int fs_mode);
        if (fs_mode == 1) begin
            wr_frame_start = 1'b1;
            @(negedge sys_clk);
            wr_frame_start = 1'b0;
            repeat (done_dly - 2) @(negedge sys_clk);
        end else begin
            repeat (done_dly - 1) @(negedge sys_clk);
        end
        sdram_done = 1'b1;
        if (fs_mode == 2) wr_frame_start = 1'b1;
        done_cyc = cyc;
        @(negedge sys_clk);
        sdram_done     = 1'b0;
        wr_frame_start = 1'b0;
        check("busy_idle", {31'd0, busy}, 32'd0);
    endtask

    task automatic serve(input int ack_dly, input int done_dly, input int fs_mode, input bit drop_rd);
        bit ok;
        wait_req(ok);
        if (!ok) return;
        ack_req(ack_dly, drop_rd);
        finish_burst(done_dly, fs_mode);
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    initial begin
        bit ok;
        int prev_done;
        int base_wfd;
        int base_bursts;

        sys_rst_n      = 1'b0;
        init_done      = 1'b0;
        wr_fifo_level  = '0;
        rd_fifo_level  = 11'd1000;
        rd_enable      = 1'b0;
        wr_frame_start = 1'b0;
        rd_frame_start = 1'b0;
        sdram_ack      = 1'b0;
        sdram_done     = 1'b0;
        repeat (3) @(negedge sys_clk);
        check("rst_wr_req", {31'd0, sdram_wr_req}, 32'd0);
        check("rst_rd_req", {31'd0, sdram_rd_req}, 32'd0);
        check("rst_addr", {8'd0, sdram_addr}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_wfd", {31'd0, wr_frame_done}, 32'd0);

        // Reset asserted in the middle of a write burst.
        init_done     = 1'b1;
        wr_fifo_level = 11'd256;
        push(1, 0);
        sys_rst_n = 1'b1;
        wait_req(ok);
        if (ok) begin
            ack_req(3, 0);
            repeat (3) @(negedge sys_clk);
            check("burst_busy", {31'd0, busy}, 32'd1);
            sys_rst_n = 1'b0;
            #1;
            check("midrst_wr_req", {31'd0, sdram_wr_req}, 32'd0);
            check("midrst_rd_req", {31'd0, sdram_rd_req}, 32'd0);
            check("midrst_addr", {8'd0, sdram_addr}, 32'd0);
            check("midrst_busy", {31'd0, busy}, 32'd0);
            check("midrst_wfd", {31'd0, wr_frame_done}, 32'd0);
            @(negedge sys_clk);
        end

        // Single write bursts: ack three cycles after request, long burst.
        push(1, 0);
        sys_rst_n = 1'b1;
        serve(3, 260, 0, 0);
        check("wr_req_len", last_req_len, 3);
        prev_done = done_cyc;
        push(1, 256);
        serve(3, 260, 0, 0);
        init_done = 1'b0;
        check("idle_gap", rise_cyc - prev_done, 2);

        // Round-robin tie.
        do_reset();
        wr_fifo_level = 11'd300;
        rd_enable     = 1'b1;
        rd_fifo_level = 11'd100;
        init_done     = 1'b1;
        push(1, 0);
        push(0, 0);
        push(1, 256);
        push(0, 256);
        for (int i = 0; i < 4; i++) begin
            serve(1, 5, 0, 0);
        end
        init_done = 1'b0;

        // Frame resync, mid-burst and coincident with done.
        do_reset();
        rd_enable     = 1'b0;
        wr_fifo_level = 11'd256;
        init_done     = 1'b1;
        base_wfd      = n_wfd;
        push(1, 0);   serve(1, 4, 0, 0);
        push(1, 256); serve(1, 4, 0, 0);
        push(1, 512); serve(1, 6, 1, 0);
        push(1, 0);   serve(1, 4, 0, 0);
        push(1, 256); serve(1, 4, 2, 0);
        push(1, 0);   serve(1, 4, 0, 0);
        init_done = 1'b0;
        repeat (2) @(negedge sys_clk);
        check("resync_no_wfd", n_wfd, base_wfd);

        // Full-frame wrap.
        do_reset();
        init_done = 1'b1;
        base_wfd  = n_wfd;
        for (int i = 0; i < 1200; i++) begin
            if (hung) break;
            if (i == 1199) check("wfd_before_wrap", n_wfd, base_wfd);
            push(1, i * 256);
            serve(1, 2, 0, 0);
        end
        push(1, 0);
        @(negedge sys_clk);
        check("wrap_wfd_count", n_wfd, base_wfd + 1);
        check("wrap_wfd_cycle", wfd_cyc - done_cyc, 1);
        serve(1, 2, 0, 0);
        init_done = 1'b0;
        repeat (3) @(negedge sys_clk);
        check("wrap_wfd_single", n_wfd, base_wfd + 1);

        // rd_enable dropped while a read request is pending.
        do_reset();
        wr_fifo_level = 11'd0;
        rd_enable     = 1'b1;
        rd_fifo_level = 11'd100;
        init_done     = 1'b1;
        push(0, 0);
        serve(3, 5, 0, 1);
        base_bursts = n_bursts;
        repeat (300) @(negedge sys_clk);
        check("rd_gated_bursts", n_bursts, base_bursts);
        check("rd_gated_busy", {31'd0, busy}, 32'd0);

        // init_done low blocks both eligible paths.
        init_done     = 1'b0;
        wr_fifo_level = 11'd300;
        rd_enable     = 1'b1;
        repeat (1000) @(negedge sys_clk);
        check("init_gated_bursts", n_bursts, base_bursts);
        check("init_gated_busy", {31'd0, busy}, 32'd0);

        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/frame_buf_arbiter.md
# frame_buf_arbiter

Schedules SDRAM burst traffic between the camera capture path and the display readout path. Watches the camera write-FIFO and display read-FIFO fill levels and issues one burst request at a time to the SDRAM controller. Grants are round-robin when both paths are eligible. Generates the frame-relative burst addresses, with wrap-around and frame resynchronisation on vsync.

## Interface
Parameters:
- ADDR_W, 24, SDRAM word-address width
- LVL_W, 11, FIFO level width
- BURST_LEN, 256, words per burst (fixed)
- FRAME_WORDS, 307200, words per frame (640x480 RGB565); must be a multiple of BURST_LEN
- WR_BASE, 0, write-region base address
- RD_BASE, 0, read-region base address
- RD_LOW, 256, read-FIFO refill threshold

Ports:
- sys_clk  in  1  system clock, all logic on rising edge
- sys_rst_n  in  1  asynchronous, active-low reset
- init_done  in  1  SDRAM + camera initialisation complete
- wr_fifo_level  in  LVL_W  words held in camera write FIFO
- rd_fifo_level  in  LVL_W  words held in display read FIFO
- rd_enable  in  1  display path active
- wr_frame_start  in  1  one-cycle pulse, camera vsync (already synchronised)
- rd_frame_start  in  1  one-cycle pulse, display frame start
- sdram_ack  in  1  controller accepted current request
- sdram_done  in  1  one-cycle pulse, current burst finished
- sdram_wr_req  out  1  write burst request
- sdram_rd_req  out  1  read burst request
- sdram_addr  out  ADDR_W  burst start address, valid while a request is high
- busy  out  1  high in any state except IDLE
- wr_frame_done  out  1  one-cycle pulse when the write address wraps

## Operation
- FSM states: IDLE, WR_REQ, WR_BURST, RD_REQ, RD_BURST.
- Eligibility, evaluated in IDLE only:
  - wr_elig = init_done && wr_fifo_level >= BURST_LEN
  - rd_elig = init_done && rd_enable && rd_fifo_level <= RD_LOW
- IDLE transitions:
  - only wr_elig -> WR_REQ; only rd_elig -> RD_REQ.
  - Both eligible -> grant the path opposite last_grant. last_grant resets to "read", so write wins the first tie.
  - last_grant updates on entry to WR_REQ or RD_REQ.
- WR_REQ/RD_REQ: sdram_x_req=1 and sdram_addr = wr_addr/rd_addr. Hold until sdram_ack=1, then go to X_BURST.
- X_BURST: requests low. Wait for sdram_done, then return to IDLE and advance the address.
  - sdram_done outside X_BURST is ignored.
  - sdram_ack outside X_REQ is ignored.
- Address advance on burst completion: addr += BURST_LEN.
  - If addr + BURST_LEN == BASE + FRAME_WORDS, addr <= BASE instead.
  - Write-path wrap pulses wr_frame_done for one cycle (the cycle after the done).
- wr_frame_start:
  - State not WR_REQ/WR_BURST: wr_addr <= WR_BASE next cycle.
  - Otherwise: set wr_resync. At burst completion, wr_addr <= WR_BASE instead of advancing, with no wr_frame_done pulse. wr_resync is then cleared.
  - rd_frame_start/rd_addr behave identically with RD_BASE.
- wr_frame_start coincident with the sdram_done that completes a write burst: resync wins, address = WR_BASE.
- init_done or rd_enable falling mid-transaction: the current request/burst completes normally; the FSM then stays in IDLE while ineligible.
- Address arithmetic is ADDR_W-bit unsigned. BASE + FRAME_WORDS must not overflow (parameter constraint, not checked).

## Timing
- Reset values: sdram_wr_req=0, sdram_rd_req=0, sdram_addr=0, busy=0, wr_frame_done=0, state=IDLE, wr_addr=WR_BASE, rd_addr=RD_BASE, last_grant=read, resync flags=0.
- All outputs are registered.
- Eligible in IDLE at cycle N -> request high at N+1, with sdram_addr valid at N+1.
- sdram_ack sampled high at cycle M -> request low at M+1, state X_BURST.
- sdram_done at cycle D -> state IDLE and updated address at D+1. Earliest next request is D+2 (minimum one IDLE cycle between bursts).
- Ack held high across multiple cycles: only the first sampled edge counts.
- Reset mid-burst: immediate return to reset values. The SDRAM controller is reset by the same sys_rst_n.

## Test plan
- Reset: assert sys_rst_n=0 mid-WR_BURST -> all outputs 0 and busy=0 in the same cycle. After release, the first write burst uses addr 0.
- Single write: init_done=1, wr_fifo_level=256, rd_enable=0, ack 3 cycles after req, done 260 cycles later -> sdram_wr_req for 3 cycles at addr 0. Next burst has addr 256, with req rising 2 cycles after done.
- Tie arbitration: wr_fifo_level=300, rd_enable=1, rd_fifo_level=100 held -> burst sequence write@0, read@0, write@256, read@256.
- Wrap: run 1200 write bursts -> burst 1200 at addr 306944, one wr_frame_done pulse after its done, burst 1201 at addr 0.
- Resync: wr_frame_start during the WR_BURST at addr 512 -> next write at addr 0, no wr_frame_done. Repeat with wr_frame_start coincident with sdram_done -> same result.
- Gating: init_done=0 with both FIFOs eligible -> no request for 1000 cycles. rd_enable dropped during RD_REQ -> request completes on ack and no further reads issue.
